// File: rtl/reg_arb_pkg.sv
// Shared constants for the register write-port arbiter: FSM state codes, default sizes, stats width.
// The optional write counter is enabled with REG_ARB_STATS_EN.
package reg_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WRITE = 2'b01
    } arb_state_e;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DATA_W  = 16;
    localparam int STATS_W     = 16;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted req at or after last_ptr+1, wrapping modulo NUM_REQ.
module rr_pick
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int PTR_W   = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   last_ptr,
    output logic [PTR_W-1:0]   winner,
    output logic               valid
);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    // Walk from the farthest candidate to the nearest so the nearest hit wins.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        sum    = '0;
        idx    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            sum = {1'b0, last_ptr} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
            idx = sum[PTR_W-1:0];
            if (req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin owner of one register's write port: IDLE arbitrates, WRITE drives one registered write.
// Define REG_ARB_STATS_EN to add the wr_count output.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      should_write,
    output logic [DATA_W-1:0]         new_value,
    output logic                      busy
`ifdef REG_ARB_STATS_EN
   ,output logic [STATS_W-1:0]        wr_count
`endif
);

    localparam int PTR_W = ptr_width(NUM_REQ);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               should_write_q, should_write_d;
    logic [DATA_W-1:0]  new_value_q, new_value_d;
    logic               busy_q, busy_d;
    logic [PTR_W-1:0]   last_ptr_q, last_ptr_d;
    logic [PTR_W-1:0]   win_q, win_d;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_vld;

    rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
        .req      (req),
        .last_ptr (last_ptr_q),
        .winner   (pick_idx),
        .valid    (pick_vld)
    );

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        should_write_d = should_write_q;
        new_value_d    = new_value_q;
        busy_d         = busy_q;
        last_ptr_d     = last_ptr_q;
        win_d          = win_q;
        case (state_q)
            ST_IDLE: begin
                grant_d        = '0;
                should_write_d = 1'b0;
                busy_d         = 1'b0;
                if (pick_vld) begin
                    grant_d[pick_idx] = 1'b1;
                    new_value_d       = wdata[int'(pick_idx)*DATA_W +: DATA_W];
                    should_write_d    = 1'b1;
                    busy_d            = 1'b1;
                    win_d             = pick_idx;
                    state_d           = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // Pointer advances only once the write has actually landed.
                last_ptr_d     = win_q;
                grant_d        = '0;
                should_write_d = 1'b0;
                busy_d         = 1'b0;
                state_d        = ST_IDLE;
            end
            default: begin
                grant_d        = '0;
                should_write_d = 1'b0;
                busy_d         = 1'b0;
                state_d        = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            grant_q        <= '0;
            should_write_q <= 1'b0;
            new_value_q    <= '0;
            busy_q         <= 1'b0;
            last_ptr_q     <= PTR_W'(NUM_REQ-1);
            win_q          <= '0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            should_write_q <= should_write_d;
            new_value_q    <= new_value_d;
            busy_q         <= busy_d;
            last_ptr_q     <= last_ptr_d;
            win_q          <= win_d;
        end
    end

    assign grant        = grant_q;
    assign should_write = should_write_q;
    assign new_value    = new_value_q;
    assign busy         = busy_q;

`ifdef REG_ARB_STATS_EN
    logic [STATS_W-1:0] wr_count_q, wr_count_d;

    always_comb begin
        wr_count_d = wr_count_q;
        if (state_q == ST_WRITE) wr_count_d = wr_count_q + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) wr_count_q <= '0;
        else       wr_count_q <= wr_count_d;
    end

    assign wr_count = wr_count_q;
`endif

endmodule
